// File: rtl/spi_master_ctrl_if.sv
// spi_master_ctrl_if: frame handshake and SPI pin bundle for spi_master_ctrl.
//   Start, Abort   : frame request / synchronous cancel (user -> controller)
//   TxLoad, TxEn   : load / shift strobes to the TX shifter
//   RxEn           : MISO sample strobe for the RX side
//   Sclk, Cs_n     : SPI clock (idles low) and active-low chip select
//   Busy, Done     : frame in progress / one-cycle completion pulse
interface spi_master_ctrl_if;
  logic Start;
  logic Abort;
  logic TxLoad;
  logic TxEn;
  logic RxEn;
  logic Sclk;
  logic Cs_n;
  logic Busy;
  logic Done;

  modport master (
    input  Start, Abort,
    output TxLoad, TxEn, RxEn, Sclk, Cs_n, Busy, Done
  );

  modport slave (
    output Start, Abort,
    input  TxLoad, TxEn, RxEn, Sclk, Cs_n, Busy, Done
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: SPI mode-0 master sequencer. Runs one SIZE-bit, MSB-first
// frame per Start, driving the TX shifter strobes, Sclk, Cs_n and the RX
// sample strobe.
//   Clk   : system clock, rising edge
//   Rst_n : asynchronous active-low reset
//   bus   : spi_master_ctrl_if.master (Start/Abort in, strobes and pins out)
//
// state | meaning
// IDLE  | waiting for Start; Cs_n high, Sclk low
// LOAD  | one cycle, parallel-load the TX shifter, Cs_n falls
// SETUP | CLKDIV cycles of MOSI setup before the first Sclk rise
// HIGH  | CLKDIV cycles Sclk high; RxEn on the rising cycle
// LOW   | CLKDIV cycles Sclk low; TxEn on the falling cycle except last bit
// DONE  | one cycle, Cs_n high, Done pulse
module spi_master_ctrl #(
  parameter int SIZE   = 8,
  parameter int CLKDIV = 2
) (
  input  logic              Clk,
  input  logic              Rst_n,
  spi_master_ctrl_if.master bus
);
  localparam int BW = $clog2(SIZE);
  localparam int DW = $clog2(CLKDIV);
  localparam logic [BW-1:0] BIT_LAST = BW'(SIZE - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SETUP, HIGH, LOW, DONE} state_t;

  state_t        state, state_nxt;
  logic [BW-1:0] bit_cnt, bit_nxt;
  logic [DW-1:0] div_cnt, div_nxt;

  logic tx_load_q, tx_en_q, rx_en_q, sclk_q, cs_n_q, busy_q, done_q;
  logic tx_load_d, tx_en_d, rx_en_d, sclk_d, cs_n_d, busy_d, done_d;

  logic div_end;
  assign div_end = (div_cnt == DIV_LAST);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      tx_load_q <= 1'b0;
      tx_en_q   <= 1'b0;
      rx_en_q   <= 1'b0;
      sclk_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      div_cnt   <= div_nxt;
      bit_cnt   <= bit_nxt;
      tx_load_q <= tx_load_d;
      tx_en_q   <= tx_en_d;
      rx_en_q   <= rx_en_d;
      sclk_q    <= sclk_d;
      cs_n_q    <= cs_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_nxt = state;
    div_nxt   = div_cnt;
    bit_nxt   = bit_cnt;
    case (state)
      IDLE: if (bus.Start) begin
        state_nxt = LOAD;
        div_nxt   = '0;
      end
      LOAD: begin
        state_nxt = SETUP;
        div_nxt   = '0;
        bit_nxt   = '0;
      end
      SETUP, HIGH: begin
        if (div_end) begin
          div_nxt   = '0;
          state_nxt = (state == SETUP) ? HIGH : LOW;
        end else begin
          div_nxt = div_cnt + DW'(1);
        end
      end
      LOW: begin
        if (div_end) begin
          div_nxt = '0;
          if (bit_cnt == BIT_LAST) begin
            state_nxt = DONE;
          end else begin
            bit_nxt   = bit_cnt + BW'(1);
            state_nxt = HIGH;
          end
        end else begin
          div_nxt = div_cnt + DW'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Abort wins over every busy-state transition; IDLE and DONE ignore it.
    if (bus.Abort && (state inside {LOAD, SETUP, HIGH, LOW})) begin
      state_nxt = IDLE;
      div_nxt   = '0;
      bit_nxt   = '0;
    end
  end

  // Outputs are decoded from the next state so they appear registered in the
  // same cycle as the state they describe. A zero phase counter marks the
  // first cycle of a phase.
  always_comb begin
    busy_d    = (state_nxt inside {LOAD, SETUP, HIGH, LOW});
    cs_n_d    = !busy_d;
    tx_load_d = (state_nxt == LOAD);
    sclk_d    = (state_nxt == HIGH);
    done_d    = (state_nxt == DONE);
    rx_en_d   = (state_nxt == HIGH) && (div_nxt == '0);
    tx_en_d   = (state_nxt == LOW) && (div_nxt == '0) && (bit_nxt != BIT_LAST);
  end

  assign bus.TxLoad = tx_load_q;
  assign bus.TxEn   = tx_en_q;
  assign bus.RxEn   = rx_en_q;
  assign bus.Sclk   = sclk_q;
  assign bus.Cs_n   = cs_n_q;
  assign bus.Busy   = busy_q;
  assign bus.Done   = done_q;
endmodule

// File: tb/tb_spi_master_ctrl.sv
module tb_spi_master_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_master_ctrl_if if0 ();
  spi_master_ctrl_if if1 ();

  spi_master_ctrl #(.SIZE(8), .CLKDIV(2)) dut0 (.Clk(clk), .Rst_n(rst_n), .bus(if0.master));
  spi_master_ctrl #(.SIZE(16), .CLKDIV(5)) dut1 (.Clk(clk), .Rst_n(rst_n), .bus(if1.master));

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [6:0] out0, out1;
  assign out0 = {if0.TxLoad, if0.TxEn, if0.RxEn, if0.Sclk, if0.Cs_n, if0.Busy, if0.Done};
  assign out1 = {if1.TxLoad, if1.TxEn, if1.RxEn, if1.Sclk, if1.Cs_n, if1.Busy, if1.Done};
  localparam logic [6:0] OUT_RST = 7'b0000100;

  // TX shifter models: parallel load from a data queue, shift left, MOSI = MSB.
  logic [7:0]  sh0;
  logic [15:0] sh1;
  logic [7:0]  data_q0[$];
  logic [15:0] data_q1[$];
  bit          exp_q0[$];
  bit          exp_q1[$];
  logic mosi0, mosi1;
  assign mosi0 = sh0[7];
  assign mosi1 = sh1[15];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) sh0 <= '0;
    else if (if0.TxLoad) begin
      if (data_q0.size() > 0) sh0 <= data_q0.pop_front();
      else sh0 <= '0;
    end else if (if0.TxEn) sh0 <= {sh0[6:0], 1'b0};
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) sh1 <= '0;
    else if (if1.TxLoad) begin
      if (data_q1.size() > 0) sh1 <= data_q1.pop_front();
      else sh1 <= '0;
    end else if (if1.TxEn) sh1 <= {sh1[14:0], 1'b0};
  end

  // Monitor for dut0 (negedge sampling)
  int rx0, tx0, done0, rise0, cs_err0, busy_run0, busy_len0, load_cnt0;
  int first_rise_off0, rise_since_load0, last_load0;
  int load_t0[$];
  logic sclk_p0 = 1'b0;
  bit e0;
  always @(negedge clk) begin
    if (if0.RxEn === 1'b1) begin
      rx0++;
      checks++;
      if (exp_q0.size() == 0) $display("FAIL mosi0_sb: RxEn with no expected bit, got %b", mosi0);
      else begin
        e0 = exp_q0.pop_front();
        if (mosi0 !== e0) $display("FAIL mosi0_bit: got %b expected %b at cycle %0d", mosi0, e0, cyc);
        else passed++;
      end
    end
    if (if0.TxEn === 1'b1) tx0++;
    if (if0.Done === 1'b1) done0++;
    if (if0.Cs_n !== !if0.Busy) cs_err0++;
    if (if0.TxLoad === 1'b1) begin
      load_cnt0++;
      load_t0.push_back(cyc);
      last_load0 = cyc;
      rise_since_load0 = 0;
    end
    if (if0.Sclk === 1'b1 && sclk_p0 === 1'b0) begin
      rise0++;
      if (rise_since_load0 == 0) first_rise_off0 = cyc - last_load0;
      rise_since_load0++;
    end
    if (if0.Busy === 1'b1) busy_run0++;
    else if (busy_run0 > 0) begin
      busy_len0 = busy_run0;
      busy_run0 = 0;
    end
    sclk_p0 = if0.Sclk;
  end

  // Monitor for dut1
  int rx1, tx1, done1, rise1, busy_run1, busy_len1, hi_run1, hp_err1, sp_err1;
  int last_rise1 = -1;
  logic sclk_p1 = 1'b0;
  bit e1;
  always @(negedge clk) begin
    if (if1.RxEn === 1'b1) begin
      rx1++;
      checks++;
      if (exp_q1.size() == 0) $display("FAIL mosi1_sb: RxEn with no expected bit, got %b", mosi1);
      else begin
        e1 = exp_q1.pop_front();
        if (mosi1 !== e1) $display("FAIL mosi1_bit: got %b expected %b at cycle %0d", mosi1, e1, cyc);
        else passed++;
      end
    end
    if (if1.TxEn === 1'b1) tx1++;
    if (if1.Done === 1'b1) done1++;
    if (if1.TxLoad === 1'b1) last_rise1 = -1;
    if (if1.Sclk === 1'b1 && sclk_p1 === 1'b0) begin
      rise1++;
      if (last_rise1 >= 0 && (cyc - last_rise1) != 10) sp_err1++;
      last_rise1 = cyc;
    end
    if (if1.Sclk === 1'b1) hi_run1++;
    else if (hi_run1 > 0) begin
      if (hi_run1 != 5) hp_err1++;
      hi_run1 = 0;
    end
    if (if1.Busy === 1'b1) busy_run1++;
    else if (busy_run1 > 0) begin
      busy_len1 = busy_run1;
      busy_run1 = 0;
    end
    sclk_p1 = if1.Sclk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // sel: 0 done0, 1 rx0, 2 tx0, 3 load_cnt0, 4 done1
  task automatic wait_cnt(input int sel, input int target, input int bound, output bit ok);
    int v;
    ok = 0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk);
      #1;
      case (sel)
        0: v = done0;
        1: v = rx0;
        2: v = tx0;
        3: v = load_cnt0;
        default: v = done1;
      endcase
      if (v >= target) ok = 1;
    end
  endtask

  task automatic push0(input logic [7:0] d);
    data_q0.push_back(d);
    for (int i = 7; i >= 0; i--) exp_q0.push_back(d[i]);
  endtask

  task automatic push1(input logic [15:0] d);
    data_q1.push_back(d);
    for (int i = 15; i >= 0; i--) exp_q1.push_back(d[i]);
  endtask

  task automatic pulse_start0();
    tick();
    if0.Start = 1'b1;
    tick();
    if0.Start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if0.Start = 1'b0; if0.Abort = 1'b0;
    if1.Start = 1'b0; if1.Abort = 1'b0;
    #12;
    checks++;
    if (out0 !== OUT_RST) $display("FAIL reset_out0: got %b expected %b", out0, OUT_RST);
    else passed++;
    checks++;
    if (out1 !== OUT_RST) $display("FAIL reset_out1: got %b expected %b", out1, OUT_RST);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    checks++;
    if (out0 !== OUT_RST) $display("FAIL idle_out0: got %b expected %b", out0, OUT_RST);
    else passed++;
  endtask

  task automatic test_single_frame();
    int r, t, d, ri, ce;
    bit ok;
    r = rx0; t = tx0; d = done0; ri = rise0; ce = cs_err0;
    push0(8'hA5);
    pulse_start0();
    wait_cnt(0, d + 1, 100, ok);
    checks++;
    if (!ok) $display("FAIL single_timeout: no Done within 100 cycles");
    else passed++;
    repeat (5) tick();
    checks++;
    if (rx0 - r !== 8) $display("FAIL single_rx: got %0d expected 8", rx0 - r); else passed++;
    checks++;
    if (tx0 - t !== 7) $display("FAIL single_tx: got %0d expected 7", tx0 - t); else passed++;
    checks++;
    if (busy_len0 !== 35) $display("FAIL single_busy: got %0d expected 35", busy_len0); else passed++;
    checks++;
    if (done0 - d !== 1) $display("FAIL single_done: got %0d expected 1", done0 - d); else passed++;
    checks++;
    if (cs_err0 - ce !== 0) $display("FAIL single_cs: got %0d mismatching cycles expected 0", cs_err0 - ce); else passed++;
    checks++;
    if (rise0 - ri !== 8) $display("FAIL single_rises: got %0d expected 8", rise0 - ri); else passed++;
    checks++;
    if (first_rise_off0 !== 3) $display("FAIL single_first_rise: got %0d expected 3", first_rise_off0); else passed++;
    checks++;
    if (exp_q0.size() !== 0) $display("FAIL single_sb_left: got %0d expected 0", exp_q0.size()); else passed++;
  endtask

  task automatic test_start_while_busy();
    int d, l, r;
    bit ok;
    d = done0; l = load_cnt0; r = rx0;
    push0(8'hC3);
    pulse_start0();
    repeat (9) tick();
    if0.Start = 1'b1;
    tick();
    if0.Start = 1'b0;
    wait_cnt(0, d + 1, 100, ok);
    checks++;
    if (!ok) $display("FAIL busy_start_timeout: no Done within 100 cycles"); else passed++;
    repeat (10) tick();
    checks++;
    if (busy_len0 !== 35) $display("FAIL busy_start_len: got %0d expected 35", busy_len0); else passed++;
    checks++;
    if (done0 - d !== 1) $display("FAIL busy_start_done: got %0d expected 1", done0 - d); else passed++;
    checks++;
    if (load_cnt0 - l !== 1) $display("FAIL busy_start_loads: got %0d expected 1", load_cnt0 - l); else passed++;
    checks++;
    if (rx0 - r !== 8) $display("FAIL busy_start_rx: got %0d expected 8", rx0 - r); else passed++;
  endtask

  task automatic test_back_to_back();
    int d, l, lt, ce, r, t;
    bit ok;
    d = done0; l = load_cnt0; lt = load_t0.size(); ce = cs_err0; r = rx0; t = tx0;
    push0(8'hFF); push0(8'h00); push0(8'h3C);
    tick();
    if0.Start = 1'b1;
    wait_cnt(3, l + 3, 200, ok);
    if0.Start = 1'b0;
    checks++;
    if (!ok) $display("FAIL b2b_load_timeout: got %0d loads expected 3", load_cnt0 - l); else passed++;
    wait_cnt(0, d + 3, 200, ok);
    repeat (5) tick();
    checks++;
    if (done0 - d !== 3) $display("FAIL b2b_done: got %0d expected 3", done0 - d); else passed++;
    checks++;
    if (load_t0.size() < lt + 3 || load_t0[lt + 1] - load_t0[lt] !== 37)
      $display("FAIL b2b_period1: got %0d expected 37", (load_t0.size() >= lt + 2) ? load_t0[lt + 1] - load_t0[lt] : -1);
    else passed++;
    checks++;
    if (load_t0.size() < lt + 3 || load_t0[lt + 2] - load_t0[lt + 1] !== 37)
      $display("FAIL b2b_period2: got %0d expected 37", (load_t0.size() >= lt + 3) ? load_t0[lt + 2] - load_t0[lt + 1] : -1);
    else passed++;
    checks++;
    if (cs_err0 - ce !== 0) $display("FAIL b2b_cs: got %0d mismatching cycles expected 0", cs_err0 - ce); else passed++;
    checks++;
    if (rx0 - r !== 24 || tx0 - t !== 21)
      $display("FAIL b2b_strobes: got rx %0d tx %0d expected rx 24 tx 21", rx0 - r, tx0 - t);
    else passed++;
  endtask

  task automatic test_abort();
    int d, l, r;
    bit ok;
    d = done0; l = load_cnt0; r = rx0;
    push0(8'h96);
    pulse_start0();
    wait_cnt(1, r + 4, 100, ok);
    if0.Abort = 1'b1;
    @(posedge clk);
    #1;
    if0.Abort = 1'b0;
    checks++;
    if (!ok || out0 !== OUT_RST) $display("FAIL abort_out: got %b expected %b (reached=%0d)", out0, OUT_RST, ok);
    else passed++;
    exp_q0.delete();
    data_q0.delete();
    repeat (10) tick();
    checks++;
    if (done0 - d !== 0 || load_cnt0 - l !== 1)
      $display("FAIL abort_quiet: got done %0d loads %0d expected done 0 loads 1", done0 - d, load_cnt0 - l);
    else passed++;
    d = done0; r = rx0;
    push0(8'h5A);
    pulse_start0();
    wait_cnt(0, d + 1, 100, ok);
    repeat (3) tick();
    checks++;
    if (!ok || busy_len0 !== 35 || rx0 - r !== 8)
      $display("FAIL abort_next_frame: got busy %0d rx %0d expected busy 35 rx 8", busy_len0, rx0 - r);
    else passed++;
  endtask

  task automatic test_async_reset();
    int d, t;
    bit ok;
    d = done0; t = tx0;
    push0(8'hF0);
    pulse_start0();
    wait_cnt(2, t + 2, 100, ok);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (!ok || out0 !== OUT_RST) $display("FAIL areset_out: got %b expected %b (reached=%0d)", out0, OUT_RST, ok);
    else passed++;
    exp_q0.delete();
    data_q0.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) tick();
    checks++;
    if (out0 !== OUT_RST || done0 - d !== 0)
      $display("FAIL areset_idle: got %b done %0d expected %b done 0", out0, done0 - d, OUT_RST);
    else passed++;
    d = done0;
    push0(8'h81);
    pulse_start0();
    wait_cnt(0, d + 1, 100, ok);
    repeat (3) tick();
    checks++;
    if (!ok || busy_len0 !== 35) $display("FAIL areset_next_frame: got busy %0d expected 35", busy_len0);
    else passed++;
  endtask

  task automatic test_param_sweep();
    int d, r, t, ri, hp, sp;
    bit ok;
    d = done1; r = rx1; t = tx1; ri = rise1; hp = hp_err1; sp = sp_err1;
    push1(16'h8001);
    tick();
    if1.Start = 1'b1;
    tick();
    if1.Start = 1'b0;
    wait_cnt(4, d + 1, 400, ok);
    checks++;
    if (!ok) $display("FAIL sweep_timeout: no Done within 400 cycles"); else passed++;
    repeat (5) tick();
    checks++;
    if (busy_len1 !== 166) $display("FAIL sweep_busy: got %0d expected 166", busy_len1); else passed++;
    checks++;
    if (rise1 - ri !== 16) $display("FAIL sweep_rises: got %0d expected 16", rise1 - ri); else passed++;
    checks++;
    if (hp_err1 - hp !== 0 || sp_err1 - sp !== 0)
      $display("FAIL sweep_halfperiod: got %0d bad high runs %0d bad spacings expected 0", hp_err1 - hp, sp_err1 - sp);
    else passed++;
    checks++;
    if (rx1 - r !== 16 || tx1 - t !== 15)
      $display("FAIL sweep_strobes: got rx %0d tx %0d expected rx 16 tx 15", rx1 - r, tx1 - t);
    else passed++;
    checks++;
    if (exp_q1.size() !== 0) $display("FAIL sweep_sb_left: got %0d expected 0", exp_q1.size()); else passed++;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_start_while_busy();
    test_back_to_back();
    test_abort();
    test_async_reset();
    test_param_sweep();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
